pipe_hazard_unit: RTL and testbench

- Parametrised hazard, forwarding and stall controller for the in-order MIPS pipeline.
- Takes decoded operand and destination fields from ID rather than raw instruction words.
- Keeps a per-stage scoreboard of in-flight writers and produces the stall signal and forwarding selects, both for the EX operand muxes and for the ID branch/jr comparators.
- Adds multi-cycle MDU (mult/div) busy tracking and a load-latency class per writer.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/haz_src_match.sv | 49 ++++
 rtl/pipe_hazard_unit.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//
// slot_t describes one in-flight register writer held in the scoreboard:
//   v    - slot holds a live writer
//   addr - destination register, zero-extended to HAZ_AW_MAX bits
//   rdy  - last slot index in which the result is not yet forwardable
//          (RDY_ALU for single-cycle producers, LOAD_RDY for loads)
package hazard_pkg;

    // Storage widths for slot fields. Register address widths up to 8 bits
    // and up to 16 scoreboard slots are supported.
    localparam int unsigned HAZ_AW_MAX = 8;
    localparam int unsigned HAZ_RDY_W  = 4;

    localparam int unsigned RDY_ALU = 0;
    localparam int unsigned SEL_RF  = 0;

    typedef struct packed {
        logic                  v;
        logic [HAZ_AW_MAX-1:0] addr;
        logic [HAZ_RDY_W-1:0]  rdy;
    } slot_t;

    // Width of a forwarding select able to name any scoreboard slot.
    function automatic int unsigned sel_width(input int unsigned num_stages);
        return (num_stages <= 1) ? 1 : $clog2(num_stages);
    endfunction

endpackage

// File: rtl/haz_src_match.sv
// Youngest-producer search for a single source register.
//
// Scans the scoreboard slots and reports the youngest (lowest index) valid
// slot whose destination matches the source address. Register 0 and unused
// sources never match.
//
// Ports:
//   slots - scoreboard contents, slot 0 = EX (youngest)
//   used  - source is actually read by the instruction in ID
//   addr  - source register address
//   hit   - a matching producer exists
//   idx   - slot index of the youngest matching producer
//   rdy   - readiness class of that producer
module haz_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned SEL_W      = 2
) (
    input  slot_t [NUM_STAGES-1:0] slots,
    input  logic                   used,
    input  logic [REG_AW-1:0]      addr,
    output logic                   hit,
    output logic [SEL_W-1:0]       idx,
    output logic [HAZ_RDY_W-1:0]   rdy
);

    logic [HAZ_AW_MAX-1:0] addr_ext;

    always_comb begin
        addr_ext               = '0;
        addr_ext[REG_AW-1:0]   = addr;
        hit                    = 1'b0;
        idx                    = '0;
        rdy                    = '0;
        if (used && (addr_ext != '0)) begin
            // Walk oldest to youngest so the youngest match is written last.
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (slots[s].v && (slots[s].addr == addr_ext)) begin
                    hit = 1'b1;
                    idx = SEL_W'(s);
                    rdy = slots[s].rdy;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall controller for the in-order MIPS pipeline.
//
// Tracks in-flight register writers in a shifting scoreboard (slot 0 = EX,
// slot NUM_STAGES-1 = WB), detects load-use and ID-consumer hazards, produces
// forwarding selects for the EX operand muxes (registered) and the ID branch
// comparators (combinational), and blocks HI/LO accesses while a mult/div is
// in progress.
//
// Optional build macro HAZ_PERF_CNT_EN adds two 32-bit stall counters
// (perf_load_stalls, perf_mdu_stalls).
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   id_valid                    - ID holds a live instruction
//   id_rs, id_rt                - source register addresses
//   id_rs_used, id_rt_used      - sources actually read
//   id_src_in_id                - sources consumed in ID (branch, jr, jalr)
//   id_wr_en, id_wr_addr        - register file write and destination
//   id_is_load                  - writer has load latency
//   id_is_mdu                   - instruction starts a mult/div
//   id_reads_hilo               - mfhi/mflo
//   stall                       - hold PC and IF/ID, bubble into EX
//   ex_fwd_rs_sel/ex_fwd_rt_sel - registered EX mux select (0 = RF, k = slot k)
//   id_fwd_rs_sel/id_fwd_rt_sel - combinational ID comparator select
//   mdu_busy                    - MDU countdown non-zero
//   perf_load_stalls            - (HAZ_PERF_CNT_EN) cycles stalled on a load
//   perf_mdu_stalls             - (HAZ_PERF_CNT_EN) cycles stalled on the MDU
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_STAGES = 3,   // minimum 3
    parameter int unsigned LOAD_RDY   = 1,
    parameter int unsigned MDU_LAT    = 32,  // minimum 2
    parameter int unsigned SEL_W      = sel_width(NUM_STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_src_in_id,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              id_is_mdu,
    input  logic              id_reads_hilo,
    output logic              stall,
    output logic [SEL_W-1:0]  ex_fwd_rs_sel,
    output logic [SEL_W-1:0]  ex_fwd_rt_sel,
    output logic [SEL_W-1:0]  id_fwd_rs_sel,
    output logic [SEL_W-1:0]  id_fwd_rt_sel,
    output logic              mdu_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_load_stalls,
    output logic [31:0]       perf_mdu_stalls
`endif
);

    localparam int unsigned CNT_W = (MDU_LAT <= 2) ? 1 : $clog2(MDU_LAT);

    slot_t [NUM_STAGES-1:0] slots_q, slots_d;
    logic  [CNT_W-1:0]      mdu_cnt_q, mdu_cnt_d;
    logic  [SEL_W-1:0]      ex_rs_q, ex_rt_q;

    logic                 rs_hit, rt_hit;
    logic [SEL_W-1:0]     rs_idx, rt_idx;
    logic [HAZ_RDY_W-1:0] rs_rdy, rt_rdy;

    logic ex_haz_rs, ex_haz_rt, id_haz_rs, id_haz_rt;
    logic data_haz, mdu_haz;

    // A producer seen from ID at slot s reaches slot s+1 when the consumer
    // enters EX; it is forwardable there only past its rdy slot.
    function automatic logic ex_haz_f(input logic hit, input logic [SEL_W-1:0] idx,
                                      input logic [HAZ_RDY_W-1:0] rdy);
        return hit && ((int'(idx) + 1) <= int'(rdy));
    endfunction

    // Next-cycle EX select. A producer in the last slot retires this cycle and
    // is read from the register file instead.
    function automatic logic [SEL_W-1:0] ex_sel_f(input logic hit,
                                                   input logic [SEL_W-1:0] idx);
        if (hit && ((int'(idx) + 1) < int'(NUM_STAGES))) begin
            return SEL_W'(int'(idx) + 1);
        end
        return SEL_W'(SEL_RF);
    endfunction

    // ID consumers need the value now, so the producer must already be past
    // its rdy slot.
    function automatic logic id_haz_f(input logic hit, input logic [SEL_W-1:0] idx,
                                      input logic [HAZ_RDY_W-1:0] rdy);
        return hit && (int'(idx) < (int'(rdy) + 1));
    endfunction

    haz_src_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs (
        .slots (slots_q),
        .used  (id_valid && id_rs_used),
        .addr  (id_rs),
        .hit   (rs_hit),
        .idx   (rs_idx),
        .rdy   (rs_rdy)
    );

    haz_src_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rt (
        .slots (slots_q),
        .used  (id_valid && id_rt_used),
        .addr  (id_rt),
        .hit   (rt_hit),
        .idx   (rt_idx),
        .rdy   (rt_rdy)
    );

    always_comb begin
        ex_haz_rs = ex_haz_f(rs_hit, rs_idx, rs_rdy);
        ex_haz_rt = ex_haz_f(rt_hit, rt_idx, rt_rdy);
        id_haz_rs = id_src_in_id && id_haz_f(rs_hit, rs_idx, rs_rdy);
        id_haz_rt = id_src_in_id && id_haz_f(rt_hit, rt_idx, rt_rdy);
        data_haz  = ex_haz_rs || ex_haz_rt || id_haz_rs || id_haz_rt;
        mdu_haz   = (mdu_cnt_q != '0) && (id_is_mdu || id_reads_hilo);
        stall     = !rst && id_valid && (data_haz || mdu_haz);
    end

    assign id_fwd_rs_sel = rs_hit ? rs_idx : SEL_W'(SEL_RF);
    assign id_fwd_rt_sel = rt_hit ? rt_idx : SEL_W'(SEL_RF);
    assign ex_fwd_rs_sel = ex_rs_q;
    assign ex_fwd_rt_sel = ex_rt_q;
    assign mdu_busy      = (mdu_cnt_q != '0);

    // Scoreboard shift: never held; a stalled ID inserts a bubble into slot 0.
    always_comb begin
        slots_d = '0;
        if (id_valid && id_wr_en && (id_wr_addr != '0) && !stall) begin
            slots_d[0].v                  = 1'b1;
            slots_d[0].addr[REG_AW-1:0]   = id_wr_addr;
            slots_d[0].rdy                = id_is_load ? HAZ_RDY_W'(LOAD_RDY)
                                                       : HAZ_RDY_W'(RDY_ALU);
        end
        for (int s = 1; s < int'(NUM_STAGES); s++) begin
            slots_d[s] = slots_q[s-1];
        end
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (id_valid && id_is_mdu && !stall) begin
            mdu_cnt_d = CNT_W'(MDU_LAT - 1);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q   <= '0;
            mdu_cnt_q <= '0;
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
        end else begin
            slots_q   <= slots_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (stall) begin
                ex_rs_q <= '0;
                ex_rt_q <= '0;
            end else begin
                ex_rs_q <= ex_sel_f(rs_hit, rs_idx);
                ex_rt_q <= ex_sel_f(rt_hit, rt_idx);
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic        load_haz;
    logic [31:0] perf_load_q, perf_mdu_q;

    // A data stall is attributed to loads only when the blocking producer is
    // a load; ALU producers stalling an ID consumer are not counted.
    assign load_haz = ((ex_haz_rs || id_haz_rs) && (rs_rdy != HAZ_RDY_W'(RDY_ALU))) ||
                      ((ex_haz_rt || id_haz_rt) && (rt_rdy != HAZ_RDY_W'(RDY_ALU)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_q <= '0;
            perf_mdu_q  <= '0;
        end else begin
            if (stall && load_haz) perf_load_q <= perf_load_q + 32'd1;
            if (stall && mdu_haz)  perf_mdu_q  <= perf_mdu_q + 32'd1;
        end
    end

    assign perf_load_stalls = perf_load_q;
    assign perf_mdu_stalls  = perf_mdu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit. Stimulus drives one ID
// instruction per cycle and queues the expected outputs for that cycle; a
// monitor pops and compares each entry on the falling edge.
module tb_pipe_hazard_unit;

    localparam int X = -1;  // don't-care expectation

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_rs_used, id_rt_used, id_src_in_id, id_wr_en;
    logic       id_is_load, id_is_mdu, id_reads_hilo;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic       stall, mdu_busy;
    logic [1:0] ex_fwd_rs_sel, ex_fwd_rt_sel, id_fwd_rs_sel, id_fwd_rt_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_load_stalls, perf_mdu_stalls;
`endif

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .id_src_in_id  (id_src_in_id),
        .id_wr_en      (id_wr_en),
        .id_wr_addr    (id_wr_addr),
        .id_is_load    (id_is_load),
        .id_is_mdu     (id_is_mdu),
        .id_reads_hilo (id_reads_hilo),
        .stall         (stall),
        .ex_fwd_rs_sel (ex_fwd_rs_sel),
        .ex_fwd_rt_sel (ex_fwd_rt_sel),
        .id_fwd_rs_sel (id_fwd_rs_sel),
        .id_fwd_rt_sel (id_fwd_rt_sel),
        .mdu_busy      (mdu_busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_load_stalls (perf_load_stalls),
        .perf_mdu_stalls  (perf_mdu_stalls)
`endif
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt;
        logic       rsu, rtu, inid, we;
        logic [4:0] wa;
        logic       ld, mdu, hilo;
    } ins_t;

    typedef struct {
        logic [127:0] nm;
        int st, exrs, exrt, idrs, idrt, busy, pl, pm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ins_t nop();
        ins_t i = '0;
        i.v = 1'b1;
        return i;
    endfunction

    function automatic ins_t alu(input int d, input int s, input int t);
        ins_t i = nop();
        i.rs = 5'(s); i.rt = 5'(t); i.rsu = 1'b1; i.rtu = 1'b1;
        i.we = 1'b1; i.wa = 5'(d);
        return i;
    endfunction

    function automatic ins_t addi(input int d, input int s);
        ins_t i = alu(d, s, 0);
        i.rtu = 1'b0;
        return i;
    endfunction

    function automatic ins_t lw(input int t, input int b);
        ins_t i = addi(t, b);
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic ins_t beq(input int s, input int t);
        ins_t i = alu(0, s, t);
        i.we = 1'b0; i.inid = 1'b1;
        return i;
    endfunction

    function automatic ins_t mult(input int s, input int t);
        ins_t i = beq(s, t);
        i.inid = 1'b0; i.mdu = 1'b1;
        return i;
    endfunction

    function automatic ins_t mfhi(input int d);
        ins_t i = nop();
        i.we = 1'b1; i.wa = 5'(d); i.hilo = 1'b1;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rs_used = i.rsu;
        id_rt_used = i.rtu; id_src_in_id = i.inid; id_wr_en = i.we;
        id_wr_addr = i.wa; id_is_load = i.ld; id_is_mdu = i.mdu;
        id_reads_hilo = i.hilo;
    endtask

    // One ID cycle: apply inputs just after the rising edge, queue expectations.
    task automatic cyc(input ins_t i, input logic [127:0] nm, input logic r,
                       input int st, input int exrs, input int exrt,
                       input int idrs, input int idrt, input int busy,
                       input int pl = -1, input int pm = -1);
        exp_t e;
        @(posedge clk);
        #1;
        drive(i);
        rst = r;
        e.nm = nm; e.st = st; e.exrs = exrs; e.exrt = exrt; e.idrs = idrs;
        e.idrt = idrt; e.busy = busy; e.pl = pl; e.pm = pm;
        sb.push_back(e);
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) cyc(nop(), "flush", 1'b0, 0, X, X, 0, 0, X);
    endtask

    task automatic chk(input logic [127:0] nm, input logic [63:0] fld,
                       input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %0s.%0s got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "stall", int'(stall), e.st);
            chk(e.nm, "ex_rs", int'(ex_fwd_rs_sel), e.exrs);
            chk(e.nm, "ex_rt", int'(ex_fwd_rt_sel), e.exrt);
            chk(e.nm, "id_rs", int'(id_fwd_rs_sel), e.idrs);
            chk(e.nm, "id_rt", int'(id_fwd_rt_sel), e.idrt);
            chk(e.nm, "busy", int'(mdu_busy), e.busy);
`ifdef HAZ_PERF_CNT_EN
            chk(e.nm, "perf_ld", int'(perf_load_stalls), e.pl);
            chk(e.nm, "perf_mdu", int'(perf_mdu_stalls), e.pm);
`endif
        end
    end

    initial begin
        ins_t b;
        drive(nop());
        // Reset state, including a would-be hazard presented during reset.
        cyc(nop(),        "rst",     1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(alu(6, 2, 2), "rst_alu", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),        "rel",     1'b0, 0, 0, 0, 0, 0, 0);

        // ALU -> ALU: forward from slot 1, no stall.
        cyc(alu(3, 1, 2), "t1_add", 1'b0, 0, 0, 0, 0, 0, 0);
        cyc(alu(4, 3, 5), "t1_sub", 1'b0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),        "t1_ex",  1'b0, 0, 1, 0, 0, 0, 0);
        flush();

        // Load-use: one stall, then both operands forward from slot 2.
        cyc(lw(2, 1),     "t2_lw",    1'b0, 0, 0, 0, 0, 0, 0);
        cyc(alu(6, 2, 2), "t2_stall", 1'b0, 1, 0, 0, 0, 0, 0);
        cyc(alu(6, 2, 2), "t2_use",   1'b0, 0, 0, 0, 1, 1, 0);
        cyc(nop(),        "t2_ex",    1'b0, 0, 2, 2, 0, 0, 0);
        flush();

        // ALU -> branch: one stall, then ID select 1.
        cyc(addi(7, 1), "t3_addi",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(beq(7, 0),  "t3_bstall", 1'b0, 1, 0, 0, 0, 0, 0);
        cyc(beq(7, 0),  "t3_beq",   1'b0, 0, 0, 0, 1, 0, 0);
        cyc(nop(),      "t3_ex",    1'b0, 0, 2, 0, 0, 0, 0);
        flush();

        // Two nops in between: no stall; select 0 once the writer retires.
        cyc(addi(7, 1), "t3b_addi", 1'b0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),      "t3b_nop",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),      "t3b_nop",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(beq(7, 0),  "t3b_far",  1'b0, 0, 0, 0, 2, 0, 0);
        cyc(beq(7, 0),  "t3b_ret",  1'b0, 0, 0, 0, 0, 0, 0);
        flush();

        // Register 0 never hazards.
        cyc(lw(0, 1),     "t5_lw0",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(alu(8, 0, 0), "t5_use0", 1'b0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),        "t5_ex0",  1'b0, 0, 0, 0, 0, 0, 0);
        flush();

        // Two writers of $9: the younger ALU (slot 0) beats the older load.
        cyc(lw(9, 1),      "t5_lw9",   1'b0, 0, 0, 0, 0, 0, 0);
        cyc(alu(9, 2, 2),  "t5_add9",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(alu(10, 9, 9), "t5_young", 1'b0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),         "t5_ex",    1'b0, 0, 1, 1, 0, 0, 0);
        flush();

        // Redirect during a would-be load-use stall: no stall.
        cyc(lw(2, 1), "rd_lw", 1'b0, 0, 0, 0, 0, 0, 0);
        b = alu(6, 2, 2);
        b.v = 1'b0;
        cyc(b,            "rd_bubble", 1'b0, 0, 0, 0, X, X, 0);
        cyc(alu(6, 2, 2), "rd_use",    1'b0, 0, X, X, 1, 1, 0);
        cyc(nop(),        "rd_ex",     1'b0, 0, 2, 2, 0, 0, 0);
        flush();

        // mult then mfhi: 31 stall cycles, proceeds on the 32nd.
        cyc(mult(1, 2), "t4_mult", 1'b0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 31; k++) cyc(mfhi(11), "t4_wait", 1'b0, 1, 0, 0, 0, 0, 1);
        cyc(mfhi(11), "t4_go", 1'b0, 0, 0, 0, 0, 0, 0);
        flush();

        // Reset mid-MDU with live EX selects.
        cyc(mult(1, 3),   "t6_mult",  1'b0, 0, 0, 0, 0, 0, 0);
        cyc(lw(2, 1),     "t6_lw",    1'b0, 0, 0, 0, 0, 0, 1);
        cyc(alu(6, 2, 2), "t6_lstall", 1'b0, 1, 0, 0, 0, 0, 1);
        cyc(alu(6, 2, 2), "t6_use",   1'b0, 0, 0, 0, 1, 1, 1);
        cyc(mfhi(11),     "t6_mstall", 1'b0, 1, 2, 2, 0, 0, 1);
        cyc(mfhi(11),     "t6_rst",   1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),        "t6_rel",   1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single load-use stall counted once, then reset mid-load-stall.
        cyc(lw(2, 1),     "t6_lw2",    1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(alu(6, 2, 2), "t6_lst2",   1'b0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(alu(6, 2, 2), "t6_use2",   1'b0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc(lw(3, 1),     "t6_lw3",    1'b0, 0, 2, 2, 0, 0, 0, 1, 0);
        cyc(alu(6, 3, 3), "t6_lst3",   1'b0, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc(alu(6, 3, 3), "t6_rst_ld", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(nop(),        "t6_rel2",   1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
